// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the InvMixColumns engine: 128-bit state in, 128-bit result out.
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: accept 128-bit state, one column per clock, 4 cycles to out_valid.
// Result is held in DONE until out_ready; in_ready only in IDLE, so no accept while a result waits.
module inv_mix_columns_seq (
  input  logic                  clk,
  input  logic                  rst,
  inv_mix_columns_seq_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   fsm;
  logic [1:0]   col;
  logic [127:0] work;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [127:0] work_nxt;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Column 0 is the most significant word of the state.
  always_comb begin
    col_in = work[127:96];
    case (col)
      2'd0:    col_in = work[127:96];
      2'd1:    col_in = work[95:64];
      2'd2:    col_in = work[63:32];
      default: col_in = work[31:0];
    endcase
  end

  assign col_out = inv_col(col_in);

  always_comb begin
    work_nxt = work;
    case (col)
      2'd0:    work_nxt[127:96] = col_out;
      2'd1:    work_nxt[95:64]  = col_out;
      2'd2:    work_nxt[63:32]  = col_out;
      default: work_nxt[31:0]   = col_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm  <= IDLE;
      col  <= 2'd0;
      work <= 128'h0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.state_in;
            col  <= 2'd0;
            fsm  <= CALC;
          end
        end
        CALC: begin
          work <= work_nxt;
          if (col == 2'd3) begin
            fsm <= DONE;
          end else begin
            col <= col + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.state_out = work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: known vectors, handshake corners, randomized round-trip.
module tb_inv_mix_columns_seq;

  localparam int N_RAND = 1000;
  localparam int LIMIT  = 30000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t vecs [3];
  logic [127:0] orig [N_RAND];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference GF(2^8) multiply by shift-and-add, independent of any xtime decomposition.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column: coefficient of a_k in b_r is base[(k - r) mod 4].
  function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inverse) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    res = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(s[127 - 8*(4*c + k) -: 8], base[(k - r + 4) % 4]);
        end
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [127:0] s, output bit ok);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.state_in = s;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [127:0] res);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = bus.state_out;
  endtask

  initial begin
    bit           ok;
    int           lat;
    int           bad;
    logic [127:0] res;
    logic [127:0] v;

    vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[1] = '{128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 128'hd4d4d4d5_2d26314c_00000000_ffffffff};
    vecs[2] = '{128'h0, 128'h0};

    bus.in_valid  = 1'b0;
    bus.state_in  = 128'h0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_state_out", bus.state_out, 128'h0);

    // Known vectors with downstream always ready.
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].din, ok);
      check("vec_accept", ok, 1);
      check("vec_no_overlap", bus.in_ready | bus.out_valid, 0);
      wait_out(lat, res);
      check("vec_latency", lat, 4);
      check("vec_result", res, vecs[i].dexp);
      @(negedge clk);
      check("vec_back_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    end

    // Backpressure: result frozen, in_valid ignored while waiting.
    bus.out_ready = 1'b0;
    v = rand128();
    send(v, ok);
    wait_out(lat, res);
    check("bp_latency", lat, 4);
    check("bp_result", res, mix(v, 1'b1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.state_in = rand128();
      @(negedge clk);
      if (bus.state_out !== res || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    check("bp_hold_cycles_bad", bad, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);

    // Reset on the second CALC cycle discards the partial state.
    send(vecs[0].din, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_state_out", bus.state_out, 128'h0);
    send(vecs[1].din, ok);
    wait_out(lat, res);
    check("midrst_latency", lat, 4);
    check("midrst_result", res, vecs[1].dexp);
    @(negedge clk);

    // state_in churns after the accept; only the accepted value matters.
    v = rand128();
    send(v, ok);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      bus.state_in = rand128();
      @(negedge clk);
      lat++;
    end
    check("stable_latency", lat, 4);
    check("stable_result", bus.state_out, mix(v, 1'b1));
    @(negedge clk);

    // Random round-trip: forward MixColumns in model, inverse in DUT, random stalls both sides.
    for (int i = 0; i < N_RAND; i++) orig[i] = rand128();
    fork
      begin
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < N_RAND && cyc < LIMIT) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.state_in = mix(orig[idx], 1'b0);
          if (bus.in_valid && bus.in_ready) idx++;
          @(negedge clk);
          cyc++;
        end
        bus.in_valid = 1'b0;
      end
      begin
        int got;
        int cyc;
        int overlap;
        got = 0;
        cyc = 0;
        overlap = 0;
        while (got < N_RAND && cyc < LIMIT) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid && bus.in_ready) overlap++;
          if (bus.out_valid && bus.out_ready) begin
            check("roundtrip", bus.state_out, orig[got]);
            got++;
          end
          @(negedge clk);
          cyc++;
        end
        check("roundtrip_count", got, N_RAND);
        check("roundtrip_overlap", overlap, 0);
      end
    join

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
